inst_prefetch: RTL
==================

INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 SHALL have parameters: WORD_BITS, default 32, data/instruction width; BURST_LENGTH, default 4, beats per fetch burst; FIFO_DEPTH, default 8, instruction buffer entries (power of 2, >= BURST_LENGTH); RESET_PC, default 0, first fetch byte address.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_permit_fetch  in  1  fetch permission from the CPU controller.
- i_inst_complete  in  1  pop the head instruction.
- i_jump  in  1  redirect request; flushes the buffer.
- i_jump_addr  in  WORD_BITS  redirect byte address.
- o_mem_addr  out  WORD_BITS  burst start byte address.
- o_mem_read  out  1  burst read request.
- o_mem_burstcount  out  4  constant BURST_LENGTH.
- i_mem_waitrequest  in  1  memory stall.
- i_mem_readdata  in  WORD_BITS  returned beat.
- i_mem_readdatavalid  in  1  beat valid.
- o_inst  out  WORD_BITS  head instruction.
- o_inst_valid  out  1  head valid (= buffer not empty).
- o_empty  out  1  buffer empty.
- o_pc  out  WORD_BITS  byte address of head instruction.
- o_fetch_complete  out  1  one-cycle pulse, burst fully buffered.

Function
REQ-003 SHALL implement FSM states IDLE, REQ, RECV, DRAIN.
REQ-004 SHALL latch a pending-fetch flag on the rising edge of i_permit_fetch (high now, low previous cycle); continuous high SHALL NOT generate further requests.
REQ-005 IDLE->REQ SHALL occur when the pending flag is set and free entries (FIFO_DEPTH - count) >= BURST_LENGTH; the flag clears on entry to REQ; otherwise the FSM stays in IDLE with the flag held.
REQ-006 In REQ, o_mem_read SHALL be 1 with o_mem_addr = fetch_pc; REQ->RECV on the first cycle with i_mem_waitrequest = 0.
REQ-007 In RECV, each beat with i_mem_readdatavalid = 1 SHALL be written to the FIFO tail; fetch_pc advances by 4 per beat.
REQ-008 On the BURST_LENGTH-th beat, the FSM SHALL return to IDLE, and o_fetch_complete SHALL pulse high for exactly the following cycle.
REQ-009 The FIFO SHALL be circular with wrap-around pointers and a count of width log2(FIFO_DEPTH)+1.
REQ-010 o_inst, o_inst_valid and o_empty SHALL be combinational from the head entry and the count.
REQ-011 o_pc SHALL hold the byte address of the head entry and advance by 4 per pop.
REQ-012 Pop SHALL occur when i_inst_complete = 1 and count > 0; a pop request while empty SHALL be ignored.
REQ-013 A simultaneous push and pop SHALL leave the count unchanged.
REQ-014 On i_jump = 1, the next edge SHALL clear the FIFO and pending flag, and set fetch_pc and o_pc to i_jump_addr.
REQ-015 i_jump SHALL take priority over a same-cycle pop and a same-cycle push; the pushed beat is discarded.
REQ-016 On i_jump in REQ, the FSM SHALL complete the handshake: hold o_mem_read until waitrequest = 0, then go to DRAIN; the issued burst address is unchanged.
REQ-017 On i_jump in RECV, the FSM SHALL go to DRAIN.
REQ-018 DRAIN SHALL discard the remaining beats of the outstanding burst and return to IDLE after the last one, without an o_fetch_complete pulse.
REQ-019 A rising edge of i_permit_fetch that arrives while in DRAIN SHALL be recorded and served after DRAIN ends.
REQ-020 fetch_pc SHALL wrap modulo 2^WORD_BITS.

Reset
REQ-021 While rst = 1, the block SHALL asynchronously hold:
- state IDLE; pointers, count and pending flag 0;
- o_mem_read = 0, o_mem_addr = RESET_PC;
- o_empty = 1, o_inst_valid = 0, o_fetch_complete = 0;
- fetch_pc = o_pc = RESET_PC.
REQ-022 Reset mid-burst SHALL abandon the burst; beats arriving after reset release with no request outstanding SHALL be ignored.

Verification
REQ-023 Bench SHALL cover basic burst: RESET_PC = 0, permit pulse, memory returns 0x11,0x22,0x33,0x44 -> o_mem_addr = 0; o_fetch_complete pulses once after beat 4; o_inst = 0x11, o_pc = 0; count = 4.
REQ-024 Bench SHALL cover backpressure: waitrequest high 3 cycles -> o_mem_read and o_mem_addr held stable for 4 cycles; exactly one burst issued.
REQ-025 Bench SHALL cover full buffer: 8 entries buffered, no pops, permit pulse -> no request; after 4 pops -> burst issued at address 0x20.
REQ-026 Bench SHALL cover jump mid-burst: i_jump with addr 0x100 after beat 2 -> beats 3-4 discarded; o_empty = 1; o_pc = 0x100; no o_fetch_complete; next permit fetches from 0x100.
REQ-027 Bench SHALL cover simultaneous events: pop plus push in the same cycle -> count unchanged; jump plus pop in the same cycle -> buffer empty and o_pc = jump address.
REQ-028 Bench SHALL cover asynchronous reset asserted between clock edges during RECV -> outputs reach reset values before the next edge; stray readdatavalid beats after release are not buffered.

Source files
------------

// File: rtl/inst_prefetch.sv
// Instruction prefetcher: turns a rising fetch permit into a fixed-length read
// burst and buffers the returned words in a circular FIFO that tracks the head PC.
module inst_prefetch #(
  parameter int unsigned          WORD_BITS    = 32,
  parameter int unsigned          BURST_LENGTH = 4,
  parameter int unsigned          FIFO_DEPTH   = 8,
  parameter logic [WORD_BITS-1:0] RESET_PC     = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_permit_fetch,
  input  logic                 i_inst_complete,
  input  logic                 i_jump,
  input  logic [WORD_BITS-1:0] i_jump_addr,
  output logic [WORD_BITS-1:0] o_mem_addr,
  output logic                 o_mem_read,
  output logic [3:0]           o_mem_burstcount,
  input  logic                 i_mem_waitrequest,
  input  logic [WORD_BITS-1:0] i_mem_readdata,
  input  logic                 i_mem_readdatavalid,
  output logic [WORD_BITS-1:0] o_inst,
  output logic                 o_inst_valid,
  output logic                 o_empty,
  output logic [WORD_BITS-1:0] o_pc,
  output logic                 o_fetch_complete
);

  localparam int unsigned          PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned          CNT_W   = PTR_W + 1;
  localparam int unsigned          BEAT_W  = $clog2(BURST_LENGTH + 1);
  localparam logic [WORD_BITS-1:0] PC_STEP = WORD_BITS'(4);

  typedef enum logic [1:0] {IDLE, REQ, RECV, DRAIN} state_e;

  state_e               state_q;
  logic                 permit_prev_q, pending_q, abort_q, mem_read_q, fetch_done_q;
  logic [WORD_BITS-1:0] mem_addr_q, fetch_pc_q, pc_q;
  logic [BEAT_W-1:0]    beat_q;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [WORD_BITS-1:0] fifo_mem [FIFO_DEPTH];

  logic permit_rise, has_room, start_fetch, last_beat, push, pop;

  assign permit_rise = i_permit_fetch & ~permit_prev_q;
  assign has_room    = (CNT_W'(FIFO_DEPTH) - count_q) >= CNT_W'(BURST_LENGTH);
  assign start_fetch = (state_q == IDLE) & pending_q & has_room & ~i_jump;
  assign last_beat   = (beat_q == BEAT_W'(BURST_LENGTH - 1));
  // A redirect wins over everything: a beat landing in the same cycle is dropped.
  assign push        = (state_q == RECV) & i_mem_readdatavalid & ~i_jump;
  assign pop         = i_inst_complete & (count_q != '0) & ~i_jump;

  // NOTE: all clocked state uses <= so every block samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      permit_prev_q <= 1'b0;
      pending_q     <= 1'b0;
      abort_q       <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_addr_q    <= RESET_PC;
      fetch_pc_q    <= RESET_PC;
      beat_q        <= '0;
      fetch_done_q  <= 1'b0;
    end else begin
      permit_prev_q <= i_permit_fetch;
      fetch_done_q  <= 1'b0;

      if (i_jump)           pending_q <= 1'b0;
      else if (permit_rise) pending_q <= 1'b1;
      else if (start_fetch) pending_q <= 1'b0;

      if (i_jump)    fetch_pc_q <= i_jump_addr;
      else if (push) fetch_pc_q <= fetch_pc_q + PC_STEP;

      case (state_q)
        IDLE: begin
          if (start_fetch) begin
            state_q    <= REQ;
            mem_read_q <= 1'b1;
            mem_addr_q <= fetch_pc_q;
            abort_q    <= 1'b0;
            beat_q     <= '0;
          end
        end
        REQ: begin
          // The address phase cannot be withdrawn; a redirect only marks the burst as dead.
          if (i_jump) abort_q <= 1'b1;
          if (!i_mem_waitrequest) begin
            mem_read_q <= 1'b0;
            state_q    <= (abort_q | i_jump) ? DRAIN : RECV;
          end
        end
        RECV, DRAIN: begin
          if (i_mem_readdatavalid) begin
            beat_q <= beat_q + BEAT_W'(1);
            if (last_beat) begin
              state_q      <= IDLE;
              fetch_done_q <= (state_q == RECV) & ~i_jump;
            end else if (i_jump) begin
              state_q <= DRAIN;
            end
          end else if (i_jump) begin
            state_q <= DRAIN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= RESET_PC;
    end else if (i_jump) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= i_jump_addr;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        pc_q     <= pc_q + PC_STEP;
      end
      if (push & ~pop)      count_q <= count_q + CNT_W'(1);
      else if (pop & ~push) count_q <= count_q - CNT_W'(1);
    end
  end

  // NOTE: the storage array has no reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= i_mem_readdata;
  end

  assign o_mem_addr       = mem_addr_q;
  assign o_mem_read       = mem_read_q;
  assign o_mem_burstcount = 4'(BURST_LENGTH);
  assign o_inst           = fifo_mem[rd_ptr_q];
  assign o_inst_valid     = (count_q != '0);
  assign o_empty          = (count_q == '0);
  assign o_pc             = pc_q;
  assign o_fetch_complete = fetch_done_q;

endmodule
